// File: rtl/svga_timing_gen.sv
`timescale 1ns/1ps
// svga_timing_gen: 800x600 @ 60 Hz video timing generator.
// Waits for the PLL lock to be stable for LOCK_DELAY+1 edges, then scans
// (x,y) over the full raster. All outputs are registered and decoded from the
// same next (h,v), so every output describes the (x,y) presented in that cycle.
module svga_timing_gen #(
   parameter int   H_VISIBLE  = 800,
   parameter int   H_FRONT    = 40,
   parameter int   H_SYNC     = 128,
   parameter int   H_BACK     = 88,
   parameter int   V_VISIBLE  = 600,
   parameter int   V_FRONT    = 1,
   parameter int   V_SYNC     = 4,
   parameter int   V_BACK     = 23,
   parameter logic HSYNC_POL  = 1'b1,
   parameter logic VSYNC_POL  = 1'b1,
   parameter int   LOCK_DELAY = 16,
   parameter int   CW         = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          locked,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic          running
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int LW      = (LOCK_DELAY < 1) ? 1 : $clog2(LOCK_DELAY + 1);

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
   localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
   localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
   localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
   localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_DELAY);

   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic [CW-1:0] h_d, v_d;
   logic          run_d;
   logic          de_d, hsync_d, vsync_d, line_start_d, frame_start_d;

   // Half-open window test used by all sync decodes.
   function automatic logic in_window(input logic [CW-1:0] val,
                                      input logic [CW-1:0] lo,
                                      input logic [CW-1:0] hi);
      return (val >= lo) && (val < hi);
   endfunction

   // Next state, lock counter, next raster position and its output decode.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      h_d        = '0;
      v_d        = '0;
      run_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (locked) begin
               state_d    = ARM;
               lock_cnt_d = LW'(1);
            end
         end
         ARM: begin
            if (!locked) begin
               state_d    = IDLE;
               lock_cnt_d = '0;
            end else if (lock_cnt_q == LOCK_MAX) begin
               // First RUN cycle presents (0,0).
               state_d = RUN;
               run_d   = 1'b1;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!locked) begin
               // Abandon the raster immediately; no partial-line completion.
               state_d    = IDLE;
               lock_cnt_d = '0;
            end else begin
               run_d = 1'b1;
               if (x == H_LAST) begin
                  h_d = '0;
                  v_d = (y == V_LAST) ? '0 : y + 1'b1;
               end else begin
                  h_d = x + 1'b1;
                  v_d = y;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            lock_cnt_d = '0;
         end
      endcase

      de_d          = run_d && (h_d < H_VIS) && (v_d < V_VIS);
      hsync_d       = (run_d && in_window(h_d, HS_START, HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = (run_d && in_window(v_d, VS_START, VS_END)) ? VSYNC_POL : ~VSYNC_POL;
      line_start_d  = run_d && (h_d == '0);
      frame_start_d = run_d && (h_d == '0) && (v_d == '0);
   end

   // State, counters and all registered outputs; rst overrides locked.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lock_cnt_q  <= '0;
         x           <= '0;
         y           <= '0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         running     <= 1'b0;
      end else begin
         state_q     <= state_d;
         lock_cnt_q  <= lock_cnt_d;
         x           <= h_d;
         y           <= v_d;
         hsync       <= hsync_d;
         vsync       <= vsync_d;
         de          <= de_d;
         line_start  <= line_start_d;
         frame_start <= frame_start_d;
         running     <= run_d;
      end
   end

endmodule

// File: tb/tb_svga_timing_gen.sv
`timescale 1ns/1ps
// Testbench for svga_timing_gen. Horizontal timing is the real 800x600 line;
// the vertical raster is shortened so that whole frames fit in a short run.
// The reference model derives every output from the count of consecutive
// edges that sampled locked=1 with rst=0.
module tb_svga_timing_gen;

   localparam int   HV = 800, HF = 40, HS = 128, HB = 88;
   localparam int   VV = 6, VF = 1, VS = 4, VB = 2;
   localparam logic HP = 1'b1, VP = 1'b1;
   localparam int   LD = 16;
   localparam int   CW = 11;
   localparam int   HT = HV + HF + HS + HB;
   localparam int   VT = VV + VF + VS + VB;
   localparam int   FT = HT * VT;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          locked = 1'b0;
   logic          hsync, vsync, de, line_start, frame_start, running;
   logic [CW-1:0] x, y;
   logic [27:0]   dut_vec;

   int     total = 0;
   int     bad   = 0;
   longint streak = 0;

   assign dut_vec = {running, de, hsync, vsync, line_start, frame_start, x, y};

   svga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(HP), .VSYNC_POL(VP), .LOCK_DELAY(LD), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst), .locked(locked),
      .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
      .line_start(line_start), .frame_start(frame_start), .running(running)
   );

   always #12.5 clk = ~clk;

   // Expected outputs after 's' consecutive locked edges.
   function automatic logic [27:0] model_vec(input longint s);
      longint t;
      int     h, v;
      logic   e_de, e_hs, e_vs;
      if (s < LD + 1)
         return {1'b0, 1'b0, ~HP, ~VP, 1'b0, 1'b0, 11'd0, 11'd0};
      t    = s - (LD + 1);
      h    = int'(t % HT);
      v    = int'((t / HT) % VT);
      e_de = (h < HV) && (v < VV);
      e_hs = (h >= HV + HF && h < HV + HF + HS) ? HP : ~HP;
      e_vs = (v >= VV + VF && v < VV + VF + VS) ? VP : ~VP;
      return {1'b1, e_de, e_hs, e_vs, (h == 0), (h == 0 && v == 0), 11'(h), 11'(v)};
   endfunction

   // Advance one edge, update the model, then settle past the edge.
   task automatic tick();
      @(posedge clk);
      if (rst || !locked) streak = 0;
      else streak++;
      #1;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1; locked = 1'b1;
      repeat (4) begin
         tick();
         total++;
         if (dut_vec !== model_vec(streak)) begin
            bad++; $display("FAIL reset_hold: got %h want %h", dut_vec, model_vec(streak));
         end
      end
      rst = 1'b0;
      n = 0;
      while (!running && n < 64) begin
         tick(); n++;
         total++;
         if (dut_vec !== model_vec(streak)) begin
            bad++; $display("FAIL arm_seq: got %h want %h", dut_vec, model_vec(streak));
         end
      end
      total++;
      if (n != LD + 1) begin
         bad++; $display("FAIL first_run_edge: got %0d want %0d", n, LD + 1);
      end
      total++;
      if ({de, frame_start, line_start, x, y} !== {1'b1, 1'b1, 1'b1, 11'd0, 11'd0}) begin
         bad++; $display("FAIL first_run_outputs: de=%b fs=%b ls=%b x=%0d y=%0d want 1 1 1 0 0",
                         de, frame_start, line_start, x, y);
      end
   endtask

   task automatic test_line();
      int last_ls = -1;
      int de_cnt = 0, hs_cnt = 0;
      logic hs_prev = 1'b0;
      for (int i = 1; i <= 3 * HT; i++) begin
         tick();
         total++;
         if (dut_vec !== model_vec(streak)) begin
            bad++; $display("FAIL line_cycle: got %h want %h", dut_vec, model_vec(streak));
         end
         if (line_start) begin
            if (last_ls >= 0) begin
               total++;
               if (i - last_ls != HT) begin
                  bad++; $display("FAIL line_period: got %0d want %0d", i - last_ls, HT);
               end
            end
            last_ls = i;
         end
         if (de) de_cnt++;
         if (hsync == HP) begin
            hs_cnt++;
            if (!hs_prev) begin
               total++;
               if (x != CW'(HV + HF)) begin
                  bad++; $display("FAIL hsync_start_x: got %0d want %0d", x, HV + HF);
               end
            end
         end
         hs_prev = (hsync == HP);
      end
      total++;
      if (de_cnt != 3 * HV) begin
         bad++; $display("FAIL line_de_count: got %0d want %0d", de_cnt, 3 * HV);
      end
      total++;
      if (hs_cnt != 3 * HS) begin
         bad++; $display("FAIL hsync_count: got %0d want %0d", hs_cnt, 3 * HS);
      end
   endtask

   task automatic test_frame();
      int nfs = 0, since = 0, vs_cnt = 0, de_cnt = 0, wraps = 0;
      int y_prev;
      y_prev = int'(y);
      for (int c = 0; c < 3 * FT && nfs < 2; c++) begin
         tick();
         total++;
         if (dut_vec !== model_vec(streak)) begin
            bad++; $display("FAIL frame_cycle: got %h want %h", dut_vec, model_vec(streak));
         end
         if (y_prev == VT - 1 && y == 0) wraps++;
         y_prev = int'(y);
         if (frame_start) begin
            if (nfs == 1) begin
               total++;
               if (since != FT) begin
                  bad++; $display("FAIL frame_period: got %0d want %0d", since, FT);
               end
               total++;
               if (vs_cnt != VS * HT) begin
                  bad++; $display("FAIL vsync_count: got %0d want %0d", vs_cnt, VS * HT);
               end
               total++;
               if (de_cnt != HV * VV) begin
                  bad++; $display("FAIL frame_de_count: got %0d want %0d", de_cnt, HV * VV);
               end
            end
            nfs++; since = 0; vs_cnt = 0; de_cnt = 0;
         end
         since++;
         if (vsync == VP) vs_cnt++;
         if (de) de_cnt++;
      end
      total++;
      if (nfs != 2) begin
         bad++; $display("FAIL frame_starts_seen: got %0d want 2", nfs);
      end
      total++;
      if (wraps != 2) begin
         bad++; $display("FAIL y_wrap: got %0d want 2", wraps);
      end
   endtask

   task automatic test_arm_glitch();
      int n;
      rst = 1'b1; tick(); rst = 1'b0; locked = 1'b1;
      repeat (10) tick();
      locked = 1'b0;
      tick();
      total++;
      if (dut_vec !== model_vec(streak) || running !== 1'b0) begin
         bad++; $display("FAIL arm_glitch_idle: got %h want %h", dut_vec, model_vec(streak));
      end
      locked = 1'b1;
      n = 0;
      while (!running && n < 64) begin
         tick(); n++;
         total++;
         if (dut_vec !== model_vec(streak)) begin
            bad++; $display("FAIL arm_glitch_seq: got %h want %h", dut_vec, model_vec(streak));
         end
      end
      total++;
      if (n != LD + 1) begin
         bad++; $display("FAIL arm_glitch_relock: got %0d want %0d", n, LD + 1);
      end
   endtask

   task automatic test_lock_loss();
      int   n;
      logic found = 1'b0;
      for (int k = 0; k < 5 * HT && !found; k++) begin
         if (x == 11'd500 && y == 11'd3) found = 1'b1;
         else begin
            tick();
            total++;
            if (dut_vec !== model_vec(streak)) begin
               bad++; $display("FAIL lock_loss_run: got %h want %h", dut_vec, model_vec(streak));
            end
         end
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL lock_loss_reach: got x=%0d y=%0d want x=500 y=3", x, y);
      end
      locked = 1'b0;
      tick();
      total++;
      if ({running, de, hsync, vsync, x, y} !== {1'b0, 1'b0, ~HP, ~VP, 11'd0, 11'd0}) begin
         bad++; $display("FAIL lock_loss_outputs: got %h want %h", dut_vec, model_vec(0));
      end
      locked = 1'b1;
      n = 0;
      while (!running && n < 64) begin
         tick(); n++;
      end
      total++;
      if (n != LD + 1 || {frame_start, x, y} !== {1'b1, 11'd0, 11'd0}) begin
         bad++; $display("FAIL lock_loss_restart: got edges=%0d fs=%b x=%0d y=%0d want %0d 1 0 0",
                         n, frame_start, x, y, LD + 1);
      end
   endtask

   task automatic test_rst_midframe();
      int n;
      repeat ($urandom_range(1000, 5000)) tick();
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) begin
         tick();
         total++;
         if (dut_vec !== model_vec(streak) || running !== 1'b0) begin
            bad++; $display("FAIL rst_mid_outputs: got %h want %h", dut_vec, model_vec(streak));
         end
      end
      rst = 1'b0;
      n = 0;
      while (!running && n < 64) begin
         tick(); n++;
      end
      total++;
      if (n != LD + 1) begin
         bad++; $display("FAIL rst_mid_resume: got %0d want %0d", n, LD + 1);
      end
   endtask

   task automatic test_random();
      int hold = 0;
      int r;
      for (int i = 0; i < 20000; i++) begin
         r = int'($urandom_range(0, 999));
         if (hold > 0) begin
            hold--;
         end else begin
            rst    = (r < 2);
            locked = !(r >= 2 && r < 6);
            if (r == 999) begin
               locked = 1'b0;
               hold   = int'($urandom_range(1, 30));
            end
         end
         tick();
         total++;
         if (dut_vec !== model_vec(streak)) begin
            bad++; $display("FAIL random_cycle: got %h want %h", dut_vec, model_vec(streak));
         end
      end
      rst = 1'b0; locked = 1'b1;
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_arm_glitch();
      test_lock_loss();
      test_rst_midframe();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
